// File: rtl/seg_reader_pkg.sv
// seg_reader_pkg: glyph constants, digit codes, FSM encoding and anode helpers for the scan reader
package seg_reader_pkg;
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_BLANK   = 4'hE;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;
  typedef enum logic [1:0] {IDLE, DWELL, CAPTURED} state_t;
  function automatic logic an_multi(input logic [3:0] an);
    logic [3:0] l;
    l = ~an;
    return (l & (l - 4'd1)) != 4'd0;
  endfunction
  function automatic logic an_onehot(input logic [3:0] an);
    return an != 4'hF && !an_multi(an);
  endfunction
  function automatic logic [1:0] an_slot(input logic [3:0] an);
    return !an[0] ? 2'd0 : !an[1] ? 2'd1 : !an[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: active-low 7-segment glyph to digit; blank gives DIGIT_BLANK, unknown gives DIGIT_INVALID
module seg_glyph_decode
  import seg_reader_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       valid,
  output logic [3:0] digit
);
  always_comb begin
    digit = glyph == GLYPH_0     ? 4'd0 :
            glyph == GLYPH_1     ? 4'd1 :
            glyph == GLYPH_2     ? 4'd2 :
            glyph == GLYPH_3     ? 4'd3 :
            glyph == GLYPH_4     ? 4'd4 :
            glyph == GLYPH_5     ? 4'd5 :
            glyph == GLYPH_6     ? 4'd6 :
            glyph == GLYPH_7     ? 4'd7 :
            glyph == GLYPH_8     ? 4'd8 :
            glyph == GLYPH_9     ? 4'd9 :
            glyph == GLYPH_BLANK ? DIGIT_BLANK : DIGIT_INVALID;
    valid = digit != DIGIT_INVALID;
  end
endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers four digits + dps from the scanned seg/an bus (SEG_READER_SYNC_EN adds a 2-flop input synchronizer)
module seg_scan_reader
  import seg_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FCNT_W        = 8
) (
  input  logic              clk,
  input  logic              btnR,
  input  logic [7:0]        seg,
  input  logic [3:0]        an,
  output logic [15:0]       digits,
  output logic [3:0]        dp,
  output logic              frame_valid,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              bad_glyph,
  output logic              bad_anode
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  if (STABLE_CYCLES < 2) begin : g_chk
    $error("STABLE_CYCLES must be at least 2");
  end
  logic [7:0] seg_i;
  logic [3:0] an_i;
`ifdef SEG_READER_SYNC_EN
  logic [11:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (btnR) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
    end
  end
  assign {an_i, seg_i} = sync2;
`else
  assign {an_i, seg_i} = {an, seg};
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   s_q;
  logic          chg, cap, set_ba, pend;
  logic [3:0]    mask, mask_n, shadow_dp;
  logic [15:0]   shadow;
  logic [1:0]    slot;
  logic          g_valid;
  logic [3:0]    g_digit;
  assign chg    = {an_i, seg_i} != s_q;
  assign slot   = an_slot(an_i);
  assign mask_n = mask | (4'b0001 << slot);
  seg_glyph_decode u_dec (
    .glyph(seg_i[6:0]),
    .valid(g_valid),
    .digit(g_digit)
  );
  // Leaving CAPTURED on a change is treated exactly like a fresh look from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    set_ba  = 1'b0;
    if (state_q == IDLE || chg) begin
      state_d = an_onehot(an_i) ? DWELL : IDLE;
      cnt_d   = CW'(1);
      set_ba  = an_multi(an_i);
    end else if (state_q == DWELL) begin
      cnt_d   = cnt_q + CW'(1);
      cap     = cnt_d == CW'(STABLE_CYCLES);
      state_d = cap ? CAPTURED : DWELL;
    end
  end
  always_ff @(posedge clk) begin
    if (btnR) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      s_q         <= '1;
      mask        <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      pend        <= 1'b0;
      digits      <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      bad_glyph   <= 1'b0;
      bad_anode   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_q         <= {an_i, seg_i};
      frame_valid <= pend;
      pend        <= 1'b0;
      if (set_ba) bad_anode <= 1'b1;
      if (pend) begin
        digits    <= shadow;
        dp        <= shadow_dp;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      // Completion publishes one edge later so the shadow already holds this capture.
      if (cap) begin
        shadow[{slot, 2'b00} +: 4] <= g_digit;
        shadow_dp[slot]            <= ~seg_i[7];
        if (!g_valid) bad_glyph <= 1'b1;
        mask <= mask_n == 4'hF ? 4'h0 : mask_n;
        pend <= mask_n == 4'hF;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: table-driven frames with a scoreboard of expected frames popped on frame_valid
module tb_seg_scan_reader;
  localparam int SC = 4;
  localparam int FW = 8;
`ifdef SEG_READER_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic          clk = 1'b0;
  logic          btnR = 1'b1;
  logic [7:0]    seg = 8'hFF;
  logic [3:0]    an = 4'hF;
  logic [15:0]   digits;
  logic [3:0]    dp;
  logic          frame_valid;
  logic [FW-1:0] frame_cnt;
  logic          bad_glyph, bad_anode;
  seg_scan_reader #(.STABLE_CYCLES(SC), .FCNT_W(FW)) dut (
    .clk(clk), .btnR(btnR), .seg(seg), .an(an),
    .digits(digits), .dp(dp), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .bad_glyph(bad_glyph), .bad_anode(bad_anode)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [15:0]   d;
    logic [3:0]    p;
    logic [FW-1:0] c;
  } exp_t;
  typedef struct {
    logic [31:0] segs;
    int          dw;
    bit          pre_ba;
    logic [15:0] d;
    logic [3:0]  p;
    bit          bg;
    bit          ba;
  } vec_t;
  exp_t          q[$];
  int            n_cmp = 0, n_bad = 0, n_fv = 0;
  logic [FW-1:0] exp_cnt = '0;
  logic [15:0]   last_d = '0;
  logic [3:0]    last_p = '0;
  logic [7:0]    gtab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  vec_t          vt[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (frame_valid) begin
      exp_t e;
      n_fv++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: frame_valid with digits %h, no frame expected at %0t", digits, $time);
      end else begin
        e = q.pop_front();
        chk("sb_digits", digits, e.d);
        chk("sb_dp", dp, e.p);
        chk("sb_frame_cnt", frame_cnt, e.c);
      end
    end
  end
  task automatic slot(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    slot(4'hF, 8'hFF, n);
  endtask
  task automatic scan(input logic [31:0] segs, input int dw);
    for (int k = 0; k < 4; k++) slot(~(4'b0001 << k), segs[8*k +: 8], dw);
  endtask
  task automatic expect_frame(input logic [15:0] d, input logic [3:0] p);
    exp_cnt = exp_cnt + 1'b1;
    q.push_back('{d, p, exp_cnt});
    last_d = d;
    last_p = p;
  endtask
  task automatic do_reset();
    btnR = 1'b1;
    idle(3);
    btnR = 1'b0;
    q.delete();
    exp_cnt = '0;
    last_d = '0;
    last_p = '0;
  endtask
  initial begin
    vt[0] = '{{8'hF9, 8'hA4, 8'hB0, 8'h99}, 3, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0};
    vt[1] = '{{8'hF9, 8'hA4, 8'hB0, 8'h99}, 8, 1'b0, 16'h1234, 4'b0000, 1'b0, 1'b0};
    vt[2] = '{{8'hF8, 8'h82, 8'h92, 8'h80}, 4, 1'b0, 16'h7658, 4'b0000, 1'b0, 1'b0};
    vt[3] = '{{8'h90, 8'h40, 8'hFF, 8'h79}, 6, 1'b0, 16'h90E1, 4'b0101, 1'b0, 1'b0};
    vt[4] = '{{8'h99, 8'hB0, 8'hA4, 8'hF9}, 8, 1'b1, 16'h4321, 4'b0000, 1'b0, 1'b1};
    vt[5] = '{{8'hB0, 8'hFF, 8'hC0, 8'hF8}, 8, 1'b0, 16'h3E07, 4'b0000, 1'b0, 1'b1};
    vt[6] = '{{8'h80, 8'h80, 8'h80, 8'hD5}, 8, 1'b0, 16'h888F, 4'b0000, 1'b1, 1'b1};
    do_reset();
    chk("rst_digits", digits, 16'h0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 7; i++) begin
      if (vt[i].pre_ba) begin
        slot(4'hC, 8'hFF, 10);
        chk("multi_anode_flag", bad_anode, 1'b1);
        idle(2);
      end
      if (vt[i].dw >= SC) expect_frame(vt[i].d, vt[i].p);
      scan(vt[i].segs, vt[i].dw);
      idle(3 + SL);
      chk("vec_digits", digits, last_d);
      chk("vec_dp", dp, last_p);
      chk("vec_frame_cnt", frame_cnt, exp_cnt);
      chk("vec_bad_glyph", bad_glyph, vt[i].bg);
      chk("vec_bad_anode", bad_anode, vt[i].ba);
    end
    do_reset();
    chk("rst2_digits", digits, 16'h0);
    chk("rst2_dp", dp, 4'h0);
    chk("rst2_frame_cnt", frame_cnt, 0);
    chk("rst2_bad_glyph", bad_glyph, 1'b0);
    chk("rst2_bad_anode", bad_anode, 1'b0);
    slot(4'hE, 8'h90, 8);
    slot(4'hD, 8'h92, 8);
    do_reset();
    slot(4'hB, 8'h40, 8);
    slot(4'h7, 8'hC0, 8);
    idle(3 + SL);
    chk("partial_no_frame_digits", digits, 16'h0);
    do_reset();
    expect_frame(16'h0059, 4'b0100);
    scan({8'hC0, 8'h40, 8'h92, 8'h90}, 8);
    idle(3 + SL);
    chk("t5_digits", digits, 16'h0059);
    chk("t5_dp", dp, 4'b0100);
    chk("t5_frame_cnt", frame_cnt, 1);
    do_reset();
    begin
      int n0;
      n0 = n_fv;
      for (int i = 0; i < 256; i++) begin
        logic [15:0] d;
        logic [31:0] segs;
        for (int k = 0; k < 4; k++) begin
          d[4*k +: 4] = 4'((i + k) % 10);
          segs[8*k +: 8] = gtab[(i + k) % 10];
        end
        expect_frame(d, 4'b0000);
        scan(segs, SC);
        if (i == 0) begin
          repeat (SL) @(posedge clk);
          @(negedge clk);
          chk("lat_fv_before", frame_valid, 1'b0);
          @(negedge clk);
          chk("lat_fv_pulse", frame_valid, 1'b1);
          chk("lat_digits", digits, d);
          @(negedge clk);
          chk("lat_fv_after", frame_valid, 1'b0);
          @(posedge clk);
          #1;
        end
      end
      idle(3 + SL);
      chk("wrap_pulses", n_fv - n0, 256);
      chk("wrap_frame_cnt", frame_cnt, 0);
    end
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
